// File: rtl/al_ram_pkg.sv
// Shared constants for the al_ram storage library.
// No ports. WID is the word width and AWID the address width.
// DEP is always derived from AWID, so every address is in range.
package al_ram_pkg;
   localparam int WID  = 256;
   localparam int AWID = 5;
   localparam int DEP  = 1 << AWID;

   function automatic int depth_of(input int awid);
      return 1 << awid;
   endfunction
endpackage

// File: rtl/al_ram_113x_if.sv
// Bus bundle for the al_ram_113x simple dual-port RAM.
// Signals:
//   ra  - read address
//   wa  - write address
//   wdi - write data
//   we  - write enable, active-high
//   rdo - registered read data
// Modports:
//   master - the user of the RAM
//   slave  - the RAM itself
interface al_ram_113x_if
   import al_ram_pkg::*;
#(
   parameter int WID  = al_ram_pkg::WID,
   parameter int AWID = al_ram_pkg::AWID
);
   logic [WID-1:0]  rdo;
   logic [WID-1:0]  wdi;
   logic [AWID-1:0] ra;
   logic [AWID-1:0] wa;
   logic            we;

   modport master (output ra, wa, wdi, we, input rdo);
   modport slave  (input ra, wa, wdi, we, output rdo);
endinterface

// File: rtl/al_ram_113x_core.sv
// Bare storage array for al_ram_113x.
// Ports:
//   clk     - clock
//   we      - write enable (already gated by the caller)
//   wa, wdi - write address and data
//   ra      - read address
//   rd      - unregistered read data, mem[ra]
// No reset on the array, and the read is a plain combinational index,
// so FPGA tools can map it onto block or distributed RAM.
module al_ram_113x_core
   import al_ram_pkg::*;
#(
   parameter int WID  = al_ram_pkg::WID,
   parameter int AWID = al_ram_pkg::AWID
) (
   input  logic            clk,
   input  logic            we,
   input  logic [AWID-1:0] wa,
   input  logic [WID-1:0]  wdi,
   input  logic [AWID-1:0] ra,
   output logic [WID-1:0]  rd
);
   localparam int DEP = depth_of(AWID);

   logic [WID-1:0] mem [DEP];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wa] <= wdi;
      end
   end

   assign rd = mem[ra];
endmodule

// File: rtl/al_ram_113x.sv
// Simple dual-port RAM with a registered, write-first read port.
// Ports:
//   clkw - write-port clock (same net as clkr)
//   clkr - read-port clock
//   rst  - asynchronous active-high reset; clears rdo and blocks writes
//   bus  - slave side of al_ram_113x_if (ra, wa, wdi, we in; rdo out)
// Memory contents survive reset; only the output register is cleared.
module al_ram_113x
   import al_ram_pkg::*;
#(
   parameter int WID  = al_ram_pkg::WID,
   parameter int AWID = al_ram_pkg::AWID
) (
   input  logic            clkw,
   input  logic            clkr,
   input  logic            rst,
   al_ram_113x_if.slave    bus
);
   logic           we_gated;
   logic           bypass;
   logic [WID-1:0] core_rd;
   logic [WID-1:0] rd_next;
   logic [WID-1:0] rdo_q;

   // A write on the same edge as a reset (or while reset is held) is dropped.
   assign we_gated = bus.we & ~rst;

   al_ram_113x_core #(
      .WID  (WID),
      .AWID (AWID)
   ) u_core (
      .clk (clkw),
      .we  (we_gated),
      .wa  (bus.wa),
      .wdi (bus.wdi),
      .ra  (bus.ra),
      .rd  (core_rd)
   );

   // Same-address read during write returns the new data.
   assign bypass  = we_gated && (bus.ra == bus.wa);
   assign rd_next = bypass ? bus.wdi : core_rd;

   always_ff @(posedge clkr or posedge rst) begin
      if (rst) begin
         rdo_q <= '0;
      end else begin
         rdo_q <= rd_next;
      end
   end

   assign bus.rdo = rdo_q;
endmodule

// File: tb/tb_al_ram_113x.sv
module tb_al_ram_113x;
   import al_ram_pkg::*;

   localparam int W = 256;
   localparam int A = 5;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   al_ram_113x_if #(.WID(W), .AWID(A)) bus ();

   al_ram_113x #(.WID(W), .AWID(A)) dut (
      .clkw (clk),
      .clkr (clk),
      .rst  (rst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [W-1:0] exp);
      n_checks++;
      assert (bus.rdo === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, bus.rdo, exp);
      end
   endtask

   task automatic wr(input logic [A-1:0] a, input logic [W-1:0] d);
      bus.we  = 1'b1;
      bus.wa  = a;
      bus.wdi = d;
      step();
      bus.we  = 1'b0;
   endtask

   task automatic rd(input logic [A-1:0] a, input logic [W-1:0] exp, input string tag);
      bus.we = 1'b0;
      bus.ra = a;
      step();
      check(tag, exp);
   endtask

   logic [W-1:0] ones;
   logic [W-1:0] top_bit;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      ones     = '1;
      top_bit  = '0;
      top_bit[W-1] = 1'b1;

      // reset held with a write pending to address 3
      rst     = 1'b1;
      bus.we  = 1'b1;
      bus.wa  = 5'd3;
      bus.wdi = 256'hDEAD;
      bus.ra  = 5'd3;
      #2;
      check("rst_async", '0);
      step();
      check("rst_cyc1", '0);
      step();
      check("rst_cyc2", '0);
      bus.we = 1'b0;
      rst    = 1'b0;
      step();
      n_checks++;
      assert (bus.rdo !== 256'hDEAD) else begin
         n_fail++;
         $error("FAIL rst_write_blocked: observed %0h expected not dead", bus.rdo);
      end

      // basic write / read
      bus.ra = 5'd0;
      wr(5'd12, 256'd1230);
      rd(5'd12, 256'd1230, "rd12");
      wr(5'd13, 256'd1330);
      rd(5'd13, 256'd1330, "rd13");
      rd(5'd12, 256'd1230, "rd12_again");

      // write-first bypass
      bus.ra = 5'd7;
      wr(5'd7, 256'hABCD);
      check("bypass7", 256'hABCD);
      rd(5'd7, 256'hABCD, "rd7_after");

      // independent ports
      wr(5'd31, 256'd99);
      bus.ra = 5'd31;
      wr(5'd0, 256'd5);
      check("indep_old31", 256'd99);
      rd(5'd0, 256'd5, "indep_rd0");

      // full width
      bus.ra = 5'd12;
      wr(5'd31, ones);
      wr(5'd0, top_bit);
      rd(5'd31, ones, "ones31");
      rd(5'd0, top_bit, "topbit0");

      // sweep all addresses
      bus.ra = 5'd1;
      for (int i = 0; i < 32; i++) begin
         wr(A'(i), W'(i) + 256'd1000);
      end
      for (int i = 0; i < 32; i++) begin
         rd(A'(i), W'(i) + 256'd1000, "sweep");
      end

      // reset mid-operation
      wr(5'd12, 256'd1230);
      rd(5'd12, 256'd1230, "pre_rst12");
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_async", '0);
      bus.we  = 1'b1;
      bus.wa  = 5'd12;
      bus.wdi = 256'd7777;
      step();
      check("mid_rst_hold", '0);
      #2;
      bus.we = 1'b0;
      rst    = 1'b0;
      rd(5'd12, 256'd1230, "post_rst12");
      rd(5'd13, 256'd1013, "post_rst13");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
